// File: rtl/alu_defs_pkg.sv
// Shared definitions for the 8-bit command sequencer and the 4-bit ALU it drives.
//   - ALU opcode constants (OP_ADD..OP_XOR, OP_NOP)
//   - Sequencer FSM state encoding
//   - Small opcode classification helpers
package alu_defs_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  // Opcode driven while the ALU is idle; the ALU answers 0 for it.
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq8_if.sv
// Command/response bus of the 8-bit ALU sequencer.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender holds valid and its payload stable until that
// edge; ready may be asserted independently of valid.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_result/rsp_flag : response channel (slave -> master)
interface alu_seq8_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_flag;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flag
  );
endinterface

// File: rtl/alu_head.sv
// 4-bit combinational ALU.
//   a, b   : operands
//   op     : OP_ADD / OP_SUB / OP_OR / OP_AND / OP_XOR; anything else gives 0
//   result : 4-bit result
//   flag   : carry-out for ADD, borrow-out for SUB, 0 otherwise
module alu_head
  import alu_defs_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       flag
);

  logic [4:0] wide;

  always_comb begin
    wide = 5'd0;
    unique case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      // Bit 4 of the 5-bit difference is the borrow.
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_OR:   wide = {1'b0, a | b};
      OP_AND:  wide = {1'b0, a & b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = 5'd0;
    endcase
    result = wide[3:0];
    flag   = wide[4];
  end

endmodule

// File: rtl/alu_seq8.sv
// 8-bit command sequencer in front of a 4-bit ALU.
// Takes ADD/SUB/OR/AND/XOR commands on bus, runs the low nibble then the
// high nibble through the external ALU, and for arithmetic adds an extra
// FIX pass that folds the low-nibble carry/borrow into the high nibble.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus                 command/response bus (slave side)
//   alu_a, alu_b        ALU operands (0 when the ALU is idle)
//   alu_op              ALU opcode (OP_NOP when idle)
//   alu_result,alu_flag ALU answer, combinational from alu_a/alu_b/alu_op
//   dbg_state           current FSM state
// Parameters:
//   NIB       ALU slice width (only 4 supported); data width is 2*NIB
//   FIX_SKIP  1: skip FIX when the low nibble produced no carry/borrow
module alu_seq8
  import alu_defs_pkg::*;
#(
  parameter int NIB      = 4,
  parameter bit FIX_SKIP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq8_if.slave      bus,
  output logic [NIB-1:0] alu_a,
  output logic [NIB-1:0] alu_b,
  output logic [2:0]     alu_op,
  input  logic [NIB-1:0] alu_result,
  input  logic           alu_flag,
  output state_t         dbg_state
);

  localparam int W = 2 * NIB;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [NIB-1:0] res_lo;
  logic [NIB-1:0] res_hi;
  logic           f_lo;
  logic           f_hi;

  assign dbg_state = state;

  // The ALU drive is registered: each transition loads the operands the
  // next state needs, so alu_result is valid throughout that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= 3'd0;
      a_q            <= '0;
      b_q            <= '0;
      res_lo         <= '0;
      res_hi         <= '0;
      f_lo           <= 1'b0;
      f_hi           <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= OP_NOP;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flag   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            a_q           <= bus.cmd_a;
            b_q           <= bus.cmd_b;
            bus.cmd_ready <= 1'b0;
            if (op_legal(bus.cmd_op)) begin
              state  <= S_LO;
              alu_a  <= bus.cmd_a[NIB-1:0];
              alu_b  <= bus.cmd_b[NIB-1:0];
              alu_op <= bus.cmd_op;
            end else begin
              // Illegal op: answer 0 straight away without touching the ALU.
              state          <= S_DONE;
              res_lo         <= '0;
              res_hi         <= '0;
              f_lo           <= 1'b0;
              f_hi           <= 1'b0;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_result <= '0;
              bus.rsp_flag   <= 1'b0;
            end
          end
        end
        S_LO: begin
          res_lo <= alu_result;
          f_lo   <= alu_flag;
          alu_a  <= a_q[W-1:NIB];
          alu_b  <= b_q[W-1:NIB];
          state  <= S_HI;
        end
        S_HI: begin
          res_hi <= alu_result;
          f_hi   <= alu_flag;
          if (op_arith(op_q) && (f_lo || !FIX_SKIP)) begin
            state <= S_FIX;
            alu_a <= alu_result;
            alu_b <= {{(NIB-1){1'b0}}, f_lo};
          end else begin
            state          <= S_DONE;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= OP_NOP;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= {alu_result, res_lo};
            bus.rsp_flag   <= op_arith(op_q) ? alu_flag : 1'b0;
          end
        end
        S_FIX: begin
          // Only one of the HI and FIX passes can carry/borrow, so OR is exact.
          res_hi         <= alu_result;
          f_hi           <= f_hi | alu_flag;
          state          <= S_DONE;
          alu_a          <= '0;
          alu_b          <= '0;
          alu_op         <= OP_NOP;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= {alu_result, res_lo};
          bus.rsp_flag   <= f_hi | alu_flag;
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq8.sv
// Bench for alu_seq8 with alu_head beside it. Two sequencers are built:
// dut (FIX_SKIP=1) and dut_ns (FIX_SKIP=0); use_ns selects which one the
// driver and the response observer talk to.
module tb_alu_seq8;
  import alu_defs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- driver-side signals ----------------
  logic       drv_valid = 1'b0;
  logic [2:0] drv_op    = 3'd0;
  logic [7:0] drv_a     = 8'd0;
  logic [7:0] drv_b     = 8'd0;
  logic       drv_ready = 1'b0;
  logic       use_ns    = 1'b0;

  alu_seq8_if bus0();
  alu_seq8_if bus1();

  assign bus0.cmd_valid = drv_valid & ~use_ns;
  assign bus0.cmd_op    = drv_op;
  assign bus0.cmd_a     = drv_a;
  assign bus0.cmd_b     = drv_b;
  assign bus0.rsp_ready = drv_ready & ~use_ns;
  assign bus1.cmd_valid = drv_valid & use_ns;
  assign bus1.cmd_op    = drv_op;
  assign bus1.cmd_a     = drv_a;
  assign bus1.cmd_b     = drv_b;
  assign bus1.rsp_ready = drv_ready & use_ns;

  logic [3:0] a0, b0, r0, a1, b1, r1;
  logic [2:0] o0, o1;
  logic       f0, f1;
  state_t     st0, st1;

  alu_seq8 #(.NIB(4), .FIX_SKIP(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus0),
    .alu_a(a0), .alu_b(b0), .alu_op(o0),
    .alu_result(r0), .alu_flag(f0), .dbg_state(st0)
  );
  alu_head alu0 (.a(a0), .b(b0), .op(o0), .result(r0), .flag(f0));

  alu_seq8 #(.NIB(4), .FIX_SKIP(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_a(a1), .alu_b(b1), .alu_op(o1),
    .alu_result(r1), .alu_flag(f1), .dbg_state(st1)
  );
  alu_head alu1 (.a(a1), .b(b1), .op(o1), .result(r1), .flag(f1));

  logic       obs_cmd_ready, obs_rsp_valid, obs_flag;
  logic [7:0] obs_result;
  assign obs_cmd_ready = use_ns ? bus1.cmd_ready  : bus0.cmd_ready;
  assign obs_rsp_valid = use_ns ? bus1.rsp_valid  : bus0.rsp_valid;
  assign obs_result    = use_ns ? bus1.rsp_result : bus0.rsp_result;
  assign obs_flag      = use_ns ? bus1.rsp_flag   : bus0.rsp_flag;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {flag, result}
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a command and returns #1 after its accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    drv_valid = 1'b1;
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
    while (!obs_cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept", 32'(obs_cmd_ready), 32'd1);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    check("busy", 32'(obs_cmd_ready), 32'd0);
  endtask

  // Waits for the response (latency counted from the accept edge), checks it
  // against the queue, stalls rsp_ready for 'hold' cycles, then consumes it.
  task automatic collect(input string tag, input int exp_lat, input int hold,
                         input bit trace, input logic [11:0] tr);
    logic [8:0] e;
    int lat;
    e = 9'h1FF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    @(negedge clk);
    lat = 1;
    while (!obs_rsp_valid && lat < 20) begin
      if (trace) begin
        if (lat == 1) check($sformatf("%s_lo", tag), 32'(r0), 32'(tr[11:8]));
        if (lat == 1) check($sformatf("%s_lo_c", tag), 32'(f0), 32'd1);
        if (lat == 2) check($sformatf("%s_hi", tag), 32'(r0), 32'(tr[7:4]));
        if (lat == 3) check($sformatf("%s_fix", tag), 32'(r0), 32'(tr[3:0]));
      end
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s_res", tag), 32'({obs_flag, obs_result}), 32'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_v", tag), 32'(obs_rsp_valid), 32'd1);
      check($sformatf("%s_hold_r", tag), 32'({obs_flag, obs_result}), 32'(e));
      check($sformatf("%s_hold_cr", tag), 32'(obs_cmd_ready), 32'd0);
    end
    drv_ready = 1'b1;
    @(posedge clk);
    #1 drv_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] er, input logic ef,
                     input int lat);
    exp_q.push_back({ef, er});
    issue(op, a, b);
    collect(tag, lat, 0, 1'b0, 12'h000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_result", 32'({bus0.rsp_flag, bus0.rsp_result}), 32'd0);
    check("rst_alu_op", 32'(o0), 32'(OP_NOP));
    check("rst_state", 32'(st0), 32'(S_IDLE));
    rst = 1'b0;

    // ADD with carry into the high nibble, with per-pass ALU trace.
    exp_q.push_back({1'b0, 8'h51});
    issue(OP_ADD, 8'h3C, 8'h15);
    collect("add_3c_15", 4, 0, 1'b1, 12'h145);

    run("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 4);
    run("add_12_34", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 3);
    run("sub_20_01", OP_SUB, 8'h20, 8'h01, 8'h1F, 1'b0, 4);
    run("sub_00_01", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 4);
    run("sub_55_23", OP_SUB, 8'h55, 8'h23, 8'h32, 1'b0, 3);
    run("xor_a5_0f", OP_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 3);
    run("or_50_0a",  OP_OR,  8'h50, 8'h0A, 8'h5A, 1'b0, 3);
    run("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 3);
    run("illegal",   3'b101, 8'hFF, 8'hFF, 8'h00, 1'b0, 1);

    // Backpressure with the next command already waiting.
    exp_q.push_back({1'b0, 8'h46});
    issue(OP_ADD, 8'h12, 8'h34);
    drv_valid = 1'b1;
    drv_op    = OP_XOR;
    drv_a     = 8'hA5;
    drv_b     = 8'h0F;
    exp_q.push_back({1'b0, 8'hAA});
    collect("bp", 3, 5, 1'b0, 12'h000);
    @(negedge clk);
    check("bp_next_ready", 32'(obs_cmd_ready), 32'd1);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    check("bp_next_state", 32'(st0), 32'(S_LO));
    collect("bp_next", 3, 0, 1'b0, 12'h000);

    // Reset while in HI: response is dropped.
    issue(OP_ADD, 8'h3C, 8'h15);
    @(posedge clk);
    #1 check("mid_state", 32'(st0), 32'(S_HI));
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(st0), 32'(S_IDLE));
    check("mid_rst_valid", 32'(bus0.rsp_valid), 32'd0);
    check("mid_rst_result", 32'({bus0.rsp_flag, bus0.rsp_result}), 32'd0);
    check("mid_rst_alu", 32'({o0, a0, b0}), 32'({OP_NOP, 8'h00}));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(bus0.rsp_valid), 32'd0);
    end
    check("mid_cmd_ready", 32'(bus0.cmd_ready), 32'd1);

    // Constant-latency variant.
    use_ns = 1'b1;
    run("ns_add_12_34", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 4);
    run("ns_xor_a5_0f", OP_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 3);
    use_ns = 1'b0;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
